// File: rtl/sram_controller.sv
// -----------------------------------------------------------------------------
// sram_controller
//
// Purpose:
//   Bridges the ARM core's MEM stage to the DE2 board's 16-bit asynchronous
//   SRAM (256K x 16). One 32-bit word read or write is split into two
//   sequential 16-bit accesses, low half first, then high half. After the
//   second half the controller idles for WAIT_CYCLES settle cycles, then
//   raises ready for exactly one cycle. The core is frozen while ready=0.
//
// Optional build macro:
//   SRAM_FAST_WRITE_EN - when defined, writes skip the settle phase
//                        (HIGH -> DONE), giving a 3-cycle write latency.
//                        Reads always use the settle phase.
//
// Parameters:
//   BASE_ADDR   - byte address of data memory word 0
//   WAIT_CYCLES - settle cycles after the second half-access (1..15)
//
// Ports:
//   clk         in   system clock
//   rst         in   asynchronous active-high reset
//   rd_en       in   read request
//   wr_en       in   write request (wins when both requests are high)
//   address     in   32-bit byte address
//   write_data  in   32-bit store data
//   read_data   out  32-bit loaded word, held between reads
//   ready       out  access done / controller free
//   SRAM_DQ     io   SRAM data bus, driven only while SRAM_WE_N=0
//   SRAM_ADDR   out  SRAM word address
//   SRAM_UB_N   out  upper byte enable (always enabled)
//   SRAM_LB_N   out  lower byte enable (always enabled)
//   SRAM_WE_N   out  write strobe, active low
//   SRAM_CE_N   out  chip enable (always enabled)
//   SRAM_OE_N   out  output enable (always enabled)
// -----------------------------------------------------------------------------
module sram_controller #(
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int          WAIT_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N,
  output logic        SRAM_WE_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N
);

  typedef enum logic [2:0] {
    IDLE,
    LOW,
    HIGH,
    WAIT,
    DONE
  } state_t;

  // Terminal value of the settle counter.
  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [16:0] idx_q, idx_d;
  logic [31:0] wdata_q, wdata_d;
  logic        is_wr_q, is_wr_d;
  logic [31:0] read_data_q, read_data_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;

  logic        drive_en;
  logic [15:0] dq_out;
  logic [31:0] offset;

  // Word index relative to the data-memory base. The subtraction wraps
  // modulo 2^32 and only bits [18:2] are kept, so the byte offset within
  // the word and everything above the SRAM size is discarded.
  assign offset = address - BASE_ADDR;

  logic unused_offset_bits;
  assign unused_offset_bits = ^{offset[31:19], offset[1:0]};

  // Byte lanes, chip and output enables are tied active. With OE held low
  // the SRAM drives DQ whenever WE_N is high, which is why the controller
  // only drives the bus in cycles where it also pulls WE_N low.
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;
  assign SRAM_WE_N = ~drive_en;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi = gi + 1) begin : g_dq_drv
      assign SRAM_DQ[gi] = drive_en ? dq_out[gi] : 1'bz;
    end
  endgenerate

  assign read_data = read_data_q;

  // Next-state, datapath and output decode.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    is_wr_d     = is_wr_q;
    read_data_d = read_data_q;
    wait_cnt_d  = wait_cnt_q;
    ready       = 1'b0;
    drive_en    = 1'b0;
    dq_out      = wdata_q[15:0];
    SRAM_ADDR   = 18'd0;

    case (state_q)
      IDLE: begin
        // Combinational so the core freezes in the same cycle it asks.
        ready = ~(rd_en | wr_en);
        if (rd_en | wr_en) begin
          idx_d   = offset[18:2];
          wdata_d = write_data;
          is_wr_d = wr_en;
          state_d = LOW;
        end
      end

      LOW: begin
        SRAM_ADDR = {idx_q, 1'b0};
        dq_out    = wdata_q[15:0];
        if (is_wr_q) begin
          drive_en = 1'b1;
        end else begin
          read_data_d[15:0] = SRAM_DQ;
        end
        state_d = HIGH;
      end

      HIGH: begin
        SRAM_ADDR  = {idx_q, 1'b1};
        dq_out     = wdata_q[31:16];
        wait_cnt_d = 4'd0;
        if (is_wr_q) begin
          drive_en = 1'b1;
        end else begin
          read_data_d[31:16] = SRAM_DQ;
        end
`ifdef SRAM_FAST_WRITE_EN
        state_d = is_wr_q ? DONE : WAIT;
`else
        state_d = WAIT;
`endif
      end

      WAIT: begin
        wait_cnt_d = wait_cnt_q + 4'd1;
        if (wait_cnt_q == WAIT_LAST) begin
          state_d = DONE;
        end
      end

      DONE: begin
        // Requests seen here belong to the access just completed; the
        // pipeline advances on this edge, so the next IDLE cycle is new.
        ready   = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= 17'd0;
      wdata_q     <= 32'd0;
      is_wr_q     <= 1'b0;
      read_data_q <= 32'd0;
      wait_cnt_q  <= 4'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
      is_wr_q     <= is_wr_d;
      read_data_q <= read_data_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// -----------------------------------------------------------------------------
// tb_sram_controller
//
// Drives word reads/writes into sram_controller against a behavioural
// 256K x 16 asynchronous SRAM. A word-level reference memory predicts the
// loaded data; expectations are queued at issue time and popped by a
// monitor whenever ready rises after an access.
// -----------------------------------------------------------------------------
module tb_sram_controller;

  localparam int W    = 3;
  localparam int BASE = 1024;
  localparam int RD_LAT = 3 + W;
`ifdef SRAM_FAST_WRITE_EN
  localparam int WR_LAT = 3;
`else
  localparam int WR_LAT = 3 + W;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_en = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] address = 32'd0;
  logic [31:0] write_data = 32'd0;
  logic [31:0] read_data;
  logic        ready;
  wire  [15:0] SRAM_DQ;
  logic [17:0] SRAM_ADDR;
  logic        SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N;

  sram_controller #(.BASE_ADDR(32'd1024), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en),
    .address(address), .write_data(write_data),
    .read_data(read_data), .ready(ready),
    .SRAM_DQ(SRAM_DQ), .SRAM_ADDR(SRAM_ADDR),
    .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N), .SRAM_WE_N(SRAM_WE_N),
    .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N)
  );

  always #5 clk = ~clk;

  // Behavioural asynchronous SRAM: OE is always asserted, so it drives the
  // bus whenever WE_N is high; a low WE_N stores the bus value.
  logic [15:0] sram [0:262143];
  assign SRAM_DQ = SRAM_WE_N ? sram[SRAM_ADDR] : 16'hzzzz;
  always @(posedge clk) begin
    if (!SRAM_WE_N) sram[SRAM_ADDR] = SRAM_DQ;
  end

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic summary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
  endtask

  // Reference model: word-addressed memory, indexed by the 17-bit word
  // index derived from the byte address.
  typedef struct {
    bit          wr;
    int unsigned idx;
    logic [31:0] data;
    int          lat;
    int          issue;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] ref_mem [int unsigned];
  logic [31:0] last_read = 32'd0;

  function automatic int unsigned idx_of(input logic [31:0] a);
    return ((a - 32'(BASE)) >> 2) & 32'h1FFFF;
  endfunction

  // Monitor: a rising ready marks completion of the oldest access.
  bit mon_en = 1'b0;
  bit post_done = 1'b0;
  bit ready_prev = 1'b1;
  int we_low = 0;
  int done_cnt = 0;
  int txn = 0;

  always @(negedge clk) begin
    exp_t e;
    logic [17:0] lo_a, hi_a;
    if (!mon_en || rst) begin
      post_done = 1'b0;
      we_low = 0;
    end else begin
      if (post_done) begin
        chk("ready_one_cycle", {31'd0, ready}, {31'd0, ~(rd_en | wr_en)});
        post_done = 1'b0;
      end
      if (!SRAM_WE_N) we_low++;
      if (ready && !ready_prev) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_ready", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          txn++;
          $display("txn %0d: %s idx=%05h data=%08h read_data=%08h latency=%0d",
                   txn, e.wr ? "WR" : "RD", e.idx, e.data, read_data, cyc - e.issue);
          chk("latency", 32'(cyc - e.issue), 32'(e.lat));
          chk("we_low_cycles", 32'(we_low), e.wr ? 32'd2 : 32'd0);
          if (e.wr) begin
            lo_a = {e.idx[16:0], 1'b0};
            hi_a = {e.idx[16:0], 1'b1};
            chk("sram_low_half", {16'd0, sram[lo_a]}, {16'd0, e.data[15:0]});
            chk("sram_high_half", {16'd0, sram[hi_a]}, {16'd0, e.data[31:16]});
            chk("read_data_hold", read_data, last_read);
          end else begin
            chk("read_data", read_data, e.data);
            last_read = e.data;
          end
        end
        done_cnt++;
        post_done = 1'b1;
        we_low = 0;
      end
    end
    ready_prev = ready;
  end

  // Present a request and queue its expected outcome.
  task automatic start_req(input bit wr, input bit rd, input logic [31:0] a,
                           input logic [31:0] d, input int issue_at);
    exp_t e;
    wr_en = wr;
    rd_en = rd;
    address = a;
    write_data = d;
    e.wr = wr;
    e.idx = idx_of(a);
    e.issue = issue_at;
    if (wr) begin
      e.data = d;
      e.lat = WR_LAT;
      ref_mem[e.idx] = d;
    end else begin
      e.data = ref_mem.exists(e.idx) ? ref_mem[e.idx] : 32'd0;
      e.lat = RD_LAT;
    end
    exp_q.push_back(e);
  endtask

  // Wait for the monitor to see completion; optionally scramble the
  // address/data inputs once the request has been latched.
  task automatic wait_done(input bit mutate);
    int start;
    start = done_cnt;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (done_cnt != start) return;
      if (mutate && i > 0) begin
        address = $urandom;
        write_data = $urandom;
      end
    end
    $display("FAIL done_timeout: no ready within 40 cycles (cycle %0d)", cyc);
    n_cmp++;
    n_bad++;
    summary();
    $fatal(1, "access never completed");
  endtask

  // b2b: request is presented during the DONE cycle and held, so it is
  // first seen by the controller in the following IDLE cycle.
  task automatic do_op(input bit wr, input bit rd, input logic [31:0] a,
                       input logic [31:0] d, input bit b2b, input bit mutate);
    if (b2b) begin
      start_req(wr, rd, a, d, cyc + 1);
    end else begin
      @(posedge clk);
      #1;
      start_req(wr, rd, a, d, cyc);
    end
    wait_done(mutate);
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  bit          r_wr, r_rd, r_b2b, r_mut;
  logic [31:0] r_a, r_d;

  initial begin
    for (int i = 0; i < 262144; i++) sram[i] = 16'h0000;

    // Reset and idle.
    #12;
    chk("reset_read_data", read_data, 32'd0);
    chk("reset_we_n", {31'd0, SRAM_WE_N}, 32'd1);
    #8 rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", {31'd0, ready}, 32'd1);
    chk("idle_we_n", {31'd0, SRAM_WE_N}, 32'd1);
    chk("idle_read_data", read_data, 32'd0);
    chk("idle_sram_addr", {14'd0, SRAM_ADDR}, 32'd0);
    mon_en = 1'b1;

    // Directed accesses.
    do_op(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 1'b0, 1'b0);
    do_op(1'b0, 1'b1, 32'd1024, 32'h0,        1'b0, 1'b0);
    do_op(1'b0, 1'b1, 32'd1024, 32'h0,        1'b1, 1'b0);
    do_op(1'b1, 1'b0, 32'd1028, 32'h12345678, 1'b0, 1'b0);
    do_op(1'b1, 1'b1, 32'd1032, 32'h0000A5A5, 1'b0, 1'b0);
    do_op(1'b1, 1'b0, 32'd1036, 32'hCAFEF00D, 1'b0, 1'b1);
    do_op(1'b0, 1'b1, 32'd1036, 32'h0,        1'b0, 1'b1);
    do_op(1'b0, 1'b1, 32'd1033, 32'h0,        1'b0, 1'b0);
    // Below the base: index wraps to the top of the SRAM.
    do_op(1'b1, 1'b0, 32'd1020, 32'h0BADF00D, 1'b0, 1'b0);
    do_op(1'b0, 1'b1, 32'd1023, 32'h0,        1'b0, 1'b0);

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      r_wr = 1'($urandom_range(0, 1));
      r_rd = r_wr ? ($urandom_range(0, 3) == 0) : 1'b1;
      if (n % 10 == 9) r_a = 32'd1024 - 32'(4 * $urandom_range(1, 3));
      else             r_a = 32'd1024 + 32'(4 * $urandom_range(0, 15));
      r_a = r_a | 32'($urandom_range(0, 3));
      r_d = $urandom;
      r_b2b = (n > 0) && ($urandom_range(0, 2) == 0);
      r_mut = 1'($urandom_range(0, 1));
      do_op(r_wr, r_rd, r_a, r_d, r_b2b, r_mut);
    end

    // Reset in the middle of a read, during the high half.
    @(posedge clk);
    #1;
    mon_en = 1'b0;
    rd_en = 1'b1;
    address = 32'd1024;
    @(posedge clk);
    #1;
    rd_en = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midop_reset_ready", {31'd0, ready}, 32'd1);
    chk("midop_reset_read_data", read_data, 32'd0);
    chk("midop_reset_we_n", {31'd0, SRAM_WE_N}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    last_read = 32'd0;
    @(negedge clk);
    chk("post_reset_ready", {31'd0, ready}, 32'd1);
    mon_en = 1'b1;
    do_op(1'b1, 1'b0, 32'd1040, 32'h600DCAFE, 1'b0, 1'b0);
    do_op(1'b0, 1'b1, 32'd1028, 32'h0,        1'b0, 1'b0);
    do_op(1'b0, 1'b1, 32'd1040, 32'h0,        1'b0, 1'b0);

    @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    summary();
    $finish;
  end

endmodule

// File: doc/sram_controller.md
Name: sram_controller

Overview:
- Memory-side stage between the ARM core's MEM stage and the DE2 board's 16-bit asynchronous SRAM (256K x 16), instantiated inside ARM_and_Sram.
- Converts one 32-bit word read or write into two sequential 16-bit SRAM accesses: low half first, then high half.
- Holds the core frozen with ready=0 until a fixed-latency access completes.

Parameters:
- BASE_ADDR, 1024: byte address of data memory word 0; subtracted before mapping onto the SRAM.
- WAIT_CYCLES, 3: idle settle cycles after the second half-access, before ready; legal range 1..15.

Ports:
- clk  input  1  system clock (CLOCK_50 at top level)
- rst  input  1  asynchronous, active-high reset (SW[0] at top level)
- rd_en  input  1  read request from MEM stage
- wr_en  input  1  write request from MEM stage
- address  input  32  byte address from ALU result
- write_data  input  32  store data
- read_data  output  32  loaded word
- ready  output  1  access done / controller free; core freeze = ~ready
- SRAM_DQ  inout  16  SRAM data bus
- SRAM_ADDR  output  18  SRAM word address
- SRAM_UB_N  output  1  upper byte enable, constant 0
- SRAM_LB_N  output  1  lower byte enable, constant 0
- SRAM_WE_N  output  1  write strobe, active low
- SRAM_CE_N  output  1  chip enable, constant 0
- SRAM_OE_N  output  1  output enable, constant 0

Behaviour:
- Reset, applied immediately:
  - state=IDLE, read_data=0, SRAM_WE_N=1, SRAM_ADDR=0, SRAM_DQ=Z, wait counter=0.
  - Reset mid-access aborts the access; a partially written word stays partially written.
- Address map:
  - idx = (address - BASE_ADDR)[18:2], 17 bits, modulo wrap; address[1:0] is ignored.
  - Low half goes to SRAM_ADDR={idx,0}, high half to {idx,1}.
- FSM states: IDLE, LOW, HIGH, WAIT, DONE.
- IDLE:
  - ready = ~(rd_en|wr_en), combinational.
  - On a request, latch address, write_data and op, then go to LOW.
  - If rd_en and wr_en are both high, the request is a write.
- LOW:
  - SRAM_ADDR={idx,0}.
  - Write: SRAM_WE_N=0 and DQ=data[15:0].
  - Read: DQ=Z and WE_N=1; read_data[15:0] <= SRAM_DQ at the clock edge.
  - Next state HIGH.
- HIGH: same as LOW using {idx,1} and bits [31:16]. Next state WAIT with counter=0.
- WAIT:
  - WE_N=1, DQ=Z; counter increments each cycle.
  - When counter==WAIT_CYCLES-1, go to DONE.
- DONE:
  - ready=1 for exactly one cycle and read_data is valid; next state IDLE.
  - Requests are ignored in DONE. A request present in the following IDLE cycle is a new access, because the pipeline advanced on the DONE cycle.
- ready is 0 in LOW, HIGH and WAIT.
- Latency: a request first seen in IDLE at cycle 0 gives ready=1 at cycle 3+WAIT_CYCLES (6 with defaults).
- read_data holds its value between reads; writes never change it.
- Input changes during LOW/HIGH/WAIT/DONE have no effect; latched values are used.
- SRAM_DQ is driven only while WE_N=0; no cycle has both controller drive and OE-driven SRAM read with WE_N high.

Optional Feature:
- Macro SRAM_FAST_WRITE_EN.
- Defined: writes go HIGH -> DONE, skipping WAIT, so write latency is 3 cycles. Reads are unchanged (3+WAIT_CYCLES).
- Undefined: reads and writes both take WAIT, as above.

Test Plan:
- Reset/idle: rst=1 for 20ns, then no requests -> ready=1, SRAM_WE_N=1, SRAM_DQ=Z, read_data=0.
- Write: wr_en, address=1024, data=0xDEADBEEF ->
  - SRAM_WE_N low for exactly 2 cycles.
  - SRAM[0]=0xBEEF, SRAM[1]=0xDEAD.
  - ready low for cycles 0..5, high at cycle 6.
- Read-back: rd_en, address=1024 -> read_data=0xDEADBEEF at the ready=1 cycle; ready high exactly one cycle, then requests in IDLE are handled as a new access.
- Mapping and priority:
  - Write 0x12345678 to address 1028 -> SRAM[2]=0x5678, SRAM[3]=0x1234.
  - rd_en=wr_en=1 at 1032 with data 0xA5A5 -> executes as a write to SRAM[4].
- Stability and reset mid-op:
  - Changing address/write_data during WAIT does not alter the stored word.
  - Asserting rst during HIGH of a read -> immediate IDLE, ready=1, read_data=0, WE_N=1.
- Fast write with SRAM_FAST_WRITE_EN defined -> write to 1024 gives ready=1 at cycle 3; a read still gives ready at cycle 6.
